// File: rtl/rail_sequencer.sv
// Power-rail sequencer: brings up the 1 V, 2 V and 3 V rails in order with power-good checks,
// sheds the 3 V rail in low-power mode and powers down in reverse order on request or low battery.
module rail_sequencer #(
   parameter int T_STEP = 100_000_000,
   parameter int CNT_W  = 28
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       on,
   input  logic       LB,
   input  logic       LP,
   input  logic       pg_1v,
   input  logic       pg_2v,
   input  logic       pg_3v,
   output logic       en_1v,
   output logic       en_2v,
   output logic       en_3v,
   output logic       ready,
   output logic       power_led,
   output logic       battery_led,
   output logic [1:0] fault_code,
   output logic [3:0] c_state
);

   typedef enum logic [3:0] {
      S_OFF    = 4'd0,
      S_UP1    = 4'd1,
      S_UP2    = 4'd2,
      S_UP3    = 4'd3,
      S_READY  = 4'd4,
      S_LOWPWR = 4'd5,
      S_DOWN3  = 4'd6,
      S_DOWN2  = 4'd7,
      S_DOWN1  = 4'd8,
      S_FAULT  = 4'd9
   } state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(T_STEP - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       fault_q, fault_d;
   logic             batt_q, batt_d;

   logic             expired;
   logic             abort;
   logic [1:0]       pg_fail;

   function automatic logic is_timed(input state_t s);
      return (s inside {S_UP1, S_UP2, S_UP3, S_DOWN3, S_DOWN2, S_DOWN1});
   endfunction

   // Lowest-index failing rail wins; 00 when all rails are good.
   function automatic logic [1:0] first_fail(input logic p1, input logic p2, input logic p3);
      if (!p1)      return 2'd1;
      else if (!p2) return 2'd2;
      else if (!p3) return 2'd3;
      else          return 2'd0;
   endfunction

   assign expired = (timer_q == '0);
   assign abort   = ~on | LB;
   assign pg_fail = first_fail(pg_1v, pg_2v, pg_3v);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_OFF;
         timer_q <= '0;
         fault_q <= 2'd0;
         batt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         fault_q <= fault_d;
         batt_q  <= batt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      batt_d  = batt_q;
      case (state_q)
         S_OFF: begin
            if (on) begin
               if (!LB) begin
                  state_d = S_UP1;
                  fault_d = 2'd0;
                  batt_d  = 1'b0;
               end else begin
                  batt_d  = 1'b1;
               end
            end
         end
         S_UP1: begin
            if (abort) begin
               state_d = S_DOWN1;
               batt_d  = LB;
            end else if (expired) begin
               if (pg_1v) begin
                  state_d = S_UP2;
               end else begin
                  state_d = S_FAULT;
                  fault_d = 2'd1;
               end
            end
         end
         S_UP2: begin
            if (abort) begin
               state_d = S_DOWN2;
               batt_d  = LB;
            end else if (expired) begin
               if (pg_2v) begin
                  state_d = S_UP3;
               end else begin
                  state_d = S_FAULT;
                  fault_d = 2'd2;
               end
            end
         end
         S_UP3: begin
            if (abort) begin
               state_d = S_DOWN3;
               batt_d  = LB;
            end else if (expired) begin
               if (pg_3v) begin
                  state_d = S_READY;
               end else begin
                  state_d = S_FAULT;
                  fault_d = 2'd3;
               end
            end
         end
         S_READY: begin
            if (pg_fail != 2'd0) begin
               state_d = S_FAULT;
               fault_d = pg_fail;
            end else if (abort) begin
               state_d = S_DOWN3;
               batt_d  = LB;
            end else if (LP) begin
               state_d = S_LOWPWR;
            end
         end
         // The 3 V rail is off here, so only rails 1 and 2 can raise a fault.
         S_LOWPWR: begin
            if (!pg_1v) begin
               state_d = S_FAULT;
               fault_d = 2'd1;
            end else if (!pg_2v) begin
               state_d = S_FAULT;
               fault_d = 2'd2;
            end else if (abort) begin
               state_d = S_DOWN2;
               batt_d  = LB;
            end else if (!LP) begin
               state_d = S_UP3;
            end
         end
         S_DOWN3: if (expired) state_d = S_DOWN2;
         S_DOWN2: if (expired) state_d = S_DOWN1;
         S_DOWN1: if (expired) state_d = S_OFF;
         S_FAULT: if (!on) state_d = S_OFF;
         default: state_d = S_OFF;
      endcase
   end

   // A timed state is only left on expiry or abort, so staying implies a nonzero timer.
   always_comb begin
      timer_d = '0;
      if (is_timed(state_d)) begin
         if (state_d != state_q) timer_d = RELOAD;
         else                    timer_d = timer_q - CNT_W'(1);
      end
   end

   always_comb begin
      en_1v = 1'b0;
      en_2v = 1'b0;
      en_3v = 1'b0;
      case (state_q)
         S_UP1, S_DOWN2: begin
            en_1v = 1'b1;
         end
         S_UP2, S_LOWPWR, S_DOWN3: begin
            en_1v = 1'b1;
            en_2v = 1'b1;
         end
         S_UP3, S_READY: begin
            en_1v = 1'b1;
            en_2v = 1'b1;
            en_3v = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign ready       = (state_q == S_READY);
   assign power_led   = en_1v | en_2v | en_3v;
   assign battery_led = batt_q;
   assign fault_code  = fault_q;
   assign c_state     = state_q;

endmodule

// File: tb/tb_rail_sequencer.sv
// Scoreboard bench for rail_sequencer with T_STEP=4: stimulus queues expected output vectors
// tagged with a cycle number, and a monitor compares them against the DUT on the falling edge.
module tb_rail_sequencer;

   logic       clk = 1'b0;
   logic       reset, on, LB, LP, pg_1v, pg_2v, pg_3v;
   logic       en_1v, en_2v, en_3v, ready, power_led, battery_led;
   logic [1:0] fault_code;
   logic [3:0] c_state;

   localparam logic [3:0] OFF = 4'd0, UP1 = 4'd1, UP2 = 4'd2, UP3 = 4'd3, RDY = 4'd4,
                          LPW = 4'd5, DN3 = 4'd6, DN2 = 4'd7, DN1 = 4'd8, FLT = 4'd9;

   typedef struct {
      int          at_cyc;
      logic [11:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   rail_sequencer #(.T_STEP(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .on(on), .LB(LB), .LP(LP),
      .pg_1v(pg_1v), .pg_2v(pg_2v), .pg_3v(pg_3v),
      .en_1v(en_1v), .en_2v(en_2v), .en_3v(en_3v), .ready(ready),
      .power_led(power_led), .battery_led(battery_led),
      .fault_code(fault_code), .c_state(c_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected output vector: {c_state, fault_code, battery_led, ready, power_led, en_3v, en_2v, en_1v}
   function automatic logic [11:0] mk(input logic [3:0] st, input logic [1:0] fc, input logic bl);
      logic e1, e2, e3;
      e1 = (st inside {UP1, UP2, UP3, RDY, LPW, DN3, DN2});
      e2 = (st inside {UP2, UP3, RDY, LPW, DN3});
      e3 = (st inside {UP3, RDY});
      return {st, fc, bl, (st == RDY), (e1 | e2 | e3), e3, e2, e1};
   endfunction

   task automatic expect_at(input int d, input logic [3:0] st, input logic [1:0] fc,
                            input logic bl, input string nm);
      exp_t e;
      e.at_cyc = cyc + d;
      e.exp    = mk(st, fc, bl);
      e.name   = nm;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   exp_t        mon_e;
   logic [11:0] mon_act;

   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = {c_state, fault_code, battery_led, ready, power_led, en_3v, en_2v, en_1v};
            n_checks++;
            if (mon_e.at_cyc == cyc && mon_act === mon_e.exp)
               n_pass++;
            else
               $display("FAIL %s cyc=%0d(due %0d) actual=%h required=%h",
                        mon_e.name, cyc, mon_e.at_cyc, mon_act, mon_e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; on = 1'b0; LB = 1'b0; LP = 1'b0;
      pg_1v = 1'b1; pg_2v = 1'b1; pg_3v = 1'b1;
      step(2);
      expect_at(0, OFF, 2'd0, 1'b0, "reset_state");
      reset = 1'b1;

      // Power-up sequence
      on = 1'b1;
      expect_at(1,  UP1, 2'd0, 1'b0, "t1_en1_rise");
      expect_at(4,  UP1, 2'd0, 1'b0, "t1_up1_last");
      expect_at(5,  UP2, 2'd0, 1'b0, "t1_en2_rise");
      expect_at(8,  UP2, 2'd0, 1'b0, "t1_up2_last");
      expect_at(9,  UP3, 2'd0, 1'b0, "t1_en3_rise");
      expect_at(12, UP3, 2'd0, 1'b0, "t1_up3_last");
      expect_at(13, RDY, 2'd0, 1'b0, "t1_ready");
      step(13);

      // pg_2v glitch in READY
      pg_2v = 1'b0;
      expect_at(1, FLT, 2'd2, 1'b0, "t2_fault");
      step(1);
      pg_2v = 1'b1;
      expect_at(1, FLT, 2'd2, 1'b0, "t2_fault_hold");
      step(1);
      on = 1'b0;
      expect_at(1, OFF, 2'd2, 1'b0, "t2_off_keeps_code");
      step(1);
      on = 1'b1;
      expect_at(1,  UP1, 2'd0, 1'b0, "t2_retry_clears");
      expect_at(13, RDY, 2'd0, 1'b0, "t2_ready_again");
      step(13);

      // Low-power shed and recovery
      LP = 1'b1;
      expect_at(1, LPW, 2'd0, 1'b0, "t3_lowpwr");
      step(1);
      pg_3v = 1'b0;
      expect_at(1, LPW, 2'd0, 1'b0, "t3_pg3_ignored");
      step(1);
      pg_3v = 1'b1;
      LP    = 1'b0;
      expect_at(1, UP3, 2'd0, 1'b0, "t3_up3_reentry");
      expect_at(4, UP3, 2'd0, 1'b0, "t3_up3_full_wait");
      expect_at(5, RDY, 2'd0, 1'b0, "t3_ready_back");
      step(5);

      // Low-battery shutdown
      LB = 1'b1;
      expect_at(1,  DN3, 2'd0, 1'b1, "t4_down3");
      expect_at(4,  DN3, 2'd0, 1'b1, "t4_down3_last");
      expect_at(5,  DN2, 2'd0, 1'b1, "t4_down2");
      expect_at(9,  DN1, 2'd0, 1'b1, "t4_down1");
      expect_at(12, DN1, 2'd0, 1'b1, "t4_down1_last");
      expect_at(13, OFF, 2'd0, 1'b1, "t4_off_batt");
      step(13);
      expect_at(3, OFF, 2'd0, 1'b1, "t4_lb_blocks_on");
      step(3);
      LB = 1'b0;
      expect_at(1,  UP1, 2'd0, 1'b0, "t4_up_clears_batt");
      expect_at(13, RDY, 2'd0, 1'b0, "t4_ready");
      step(13);

      // Fault outranks abort; lowest failing rail is reported
      pg_1v = 1'b0; pg_3v = 1'b0; on = 1'b0;
      expect_at(1, FLT, 2'd1, 1'b0, "t7_lowest_rail");
      step(1);
      pg_1v = 1'b1; pg_3v = 1'b1;
      expect_at(1, OFF, 2'd1, 1'b0, "t7_fault_exit");
      step(1);

      // Abort from LOWPWR descends from DOWN2
      on = 1'b1;
      expect_at(1,  UP1, 2'd0, 1'b0, "t8_up1");
      expect_at(13, RDY, 2'd0, 1'b0, "t8_ready");
      step(13);
      LP = 1'b1;
      expect_at(1, LPW, 2'd0, 1'b0, "t8_lowpwr");
      step(1);
      on = 1'b0;
      expect_at(1, DN2, 2'd0, 1'b0, "t8_down2");
      expect_at(5, DN1, 2'd0, 1'b0, "t8_down1");
      expect_at(9, OFF, 2'd0, 1'b0, "t8_off");
      step(9);
      LP = 1'b0;

      // Rail 3 never good
      pg_3v = 1'b0;
      on    = 1'b1;
      expect_at(1,  UP1, 2'd0, 1'b0, "t5_up1");
      expect_at(9,  UP3, 2'd0, 1'b0, "t5_up3");
      expect_at(12, UP3, 2'd0, 1'b0, "t5_up3_last");
      expect_at(13, FLT, 2'd3, 1'b0, "t5_fault3");
      step(13);
      expect_at(2, FLT, 2'd3, 1'b0, "t5_fault_needs_off");
      step(2);
      on = 1'b0;
      expect_at(1, OFF, 2'd3, 1'b0, "t5_off");
      step(1);

      // Abort coinciding with UP2 expiry
      pg_3v = 1'b1;
      on    = 1'b1;
      expect_at(1, UP1, 2'd0, 1'b0, "t5b_up1");
      step(8);
      expect_at(0, UP2, 2'd0, 1'b0, "t5b_up2_expiring");
      on = 1'b0;
      expect_at(1, DN2, 2'd0, 1'b0, "t5b_abort_wins");
      expect_at(5, DN1, 2'd0, 1'b0, "t5b_down1");
      expect_at(9, OFF, 2'd0, 1'b0, "t5b_off");
      step(9);

      // LB abort during UP1, then reset clears battery_led
      on = 1'b1;
      expect_at(1, UP1, 2'd0, 1'b0, "t9_up1");
      step(2);
      LB = 1'b1;
      expect_at(1, DN1, 2'd0, 1'b1, "t9_down1_batt");
      expect_at(4, DN1, 2'd0, 1'b1, "t9_down1_last");
      expect_at(5, OFF, 2'd0, 1'b1, "t9_off_batt");
      step(5);
      reset = 1'b0;
      expect_at(1, OFF, 2'd0, 1'b0, "t9_reset_clears");
      step(1);
      reset = 1'b1; LB = 1'b0; on = 1'b0;
      step(1);

      // Reset in the middle of UP2
      on = 1'b1;
      expect_at(1, UP1, 2'd0, 1'b0, "t6_up1");
      step(6);
      expect_at(0, UP2, 2'd0, 1'b0, "t6_in_up2");
      reset = 1'b0;
      expect_at(1, OFF, 2'd0, 1'b0, "t6_reset_mid");
      step(1);
      reset = 1'b1;
      on    = 1'b0;
      expect_at(1, OFF, 2'd0, 1'b0, "t6_idle");
      step(1);
      on = 1'b1;
      expect_at(1,  UP1, 2'd0, 1'b0, "t6_restart");
      expect_at(5,  UP2, 2'd0, 1'b0, "t6_up2");
      expect_at(13, RDY, 2'd0, 1'b0, "t6_ready");
      step(13);

      for (int i = 0; i < 40 && sb.size() > 0; i++) step(1);
      if (sb.size() > 0) begin
         $display("FAIL drain pending=%0d required=0", sb.size());
         n_checks += sb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
